dmi_req_arbiter: RTL and testbench

DMI_REQ_ARBITER -- requirements
Module: dmi_req_arbiter

---
 rtl/dmi_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmi_req_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmi_req_arbiter.sv
// rtl/dmi_req_arbiter.sv - two-requester DMI arbiter with one outstanding transaction and response timeout
// Requesters share a single downstream DMI port; a stalled target is answered with a synthetic failure.

package dm;
    localparam logic [1:0] DTM_NOP     = 2'd0;
    localparam logic [1:0] DTM_READ    = 2'd1;
    localparam logic [1:0] DTM_WRITE   = 2'd2;
    localparam logic [1:0] DTM_SUCCESS = 2'd0;
    localparam logic [1:0] DTM_ERR     = 2'd2;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;
endpackage

module dmi_req_arbiter #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic          tck_i,
    input  logic          trst_ni,
    input  dm::dmi_req_t  req0_i,
    input  logic          req0_valid_i,
    output logic          req0_ready_o,
    input  dm::dmi_req_t  req1_i,
    input  logic          req1_valid_i,
    output logic          req1_ready_o,
    output dm::dmi_resp_t resp0_o,
    output logic          resp0_valid_o,
    input  logic          resp0_ready_i,
    output dm::dmi_resp_t resp1_o,
    output logic          resp1_valid_o,
    input  logic          resp1_ready_i,
    output dm::dmi_req_t  dmi_req_o,
    output logic          dmi_req_valid_o,
    input  logic          dmi_req_ready_i,
    input  dm::dmi_resp_t dmi_resp_i,
    input  logic          dmi_resp_valid_i,
    output logic          dmi_resp_ready_o,
    output logic          busy_o
);

    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e        state_q;
    logic          owner_q;
    logic          last_grant_q;
    logic          drop_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_inc;
    dm::dmi_req_t  req_q;
    dm::dmi_resp_t resp_q;

    logic grant0;
    logic grant1;
    logic owner_ready;
    logic timeout_hit;

    // On a tie the requester that was not served last wins.
    assign grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
    assign grant1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);

    assign req0_ready_o     = (state_q == IDLE) & grant0;
    assign req1_ready_o     = (state_q == IDLE) & grant1;
    assign dmi_req_valid_o  = (state_q == REQ);
    assign dmi_req_o        = req_q;
    assign dmi_resp_ready_o = (state_q == WAIT) | drop_q;
    assign resp0_valid_o    = (state_q == RESP) & ~owner_q;
    assign resp1_valid_o    = (state_q == RESP) & owner_q;
    assign resp0_o          = resp_q;
    assign resp1_o          = resp_q;
    assign busy_o           = (state_q != IDLE);

    assign owner_ready = owner_q ? resp1_ready_i : resp0_ready_i;
    assign cnt_inc     = cnt_q + CntW'(1);
    assign timeout_hit = (TimeoutCycles != 0) && (cnt_inc == CntMax);

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            drop_q       <= 1'b0;
            cnt_q        <= '0;
            req_q        <= '0;
            resp_q       <= '0;
        end else begin
            // A late answer to a timed-out transaction is swallowed wherever it lands.
            if ((state_q != WAIT) && drop_q && dmi_resp_valid_i) begin
                drop_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (grant0) begin
                        req_q   <= req0_i;
                        owner_q <= 1'b0;
                        state_q <= REQ;
                    end else if (grant1) begin
                        req_q   <= req1_i;
                        owner_q <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (dmi_req_ready_i) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmi_resp_valid_i && !drop_q) begin
                        resp_q  <= dmi_resp_i;
                        state_q <= RESP;
                    end else begin
                        if (dmi_resp_valid_i) begin
                            drop_q <= 1'b0;
                        end
                        if (cnt_q != CntMax) begin
                            cnt_q <= cnt_inc;
                        end
                        if (timeout_hit) begin
                            resp_q.data <= '0;
                            resp_q.resp <= dm::DTM_ERR;
                            drop_q      <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (owner_ready) begin
                        last_grant_q <= owner_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// tb/tb_dmi_req_arbiter.sv - directed self-checking bench for dmi_req_arbiter

module tb_dmi_req_arbiter;
    logic          tck = 1'b0;
    logic          trst_ni = 1'b0;
    dm::dmi_req_t  req0 = '0, req1 = '0, dmi_req;
    logic          req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
    dm::dmi_resp_t resp0, resp1, dmi_resp = '0;
    logic          resp0_valid, resp1_valid, resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic          dmi_req_valid, dmi_req_ready = 1'b0;
    logic          dmi_resp_valid = 1'b0, dmi_resp_ready, busy;
    int            errors = 0;
    int            checks = 0;

    always #5 tck = ~tck;

    dmi_req_arbiter #(.TimeoutCycles(4)) dut (
        .tck_i(tck), .trst_ni(trst_ni),
        .req0_i(req0), .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req1_i(req1), .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .resp0_o(resp0), .resp0_valid_o(resp0_valid), .resp0_ready_i(resp0_ready),
        .resp1_o(resp1), .resp1_valid_o(resp1_valid), .resp1_ready_i(resp1_ready),
        .dmi_req_o(dmi_req), .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready),
        .dmi_resp_i(dmi_resp), .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready),
        .busy_o(busy)
    );

    task automatic test_reset;
        @(negedge tck);
        checks++; if ({busy, dmi_req_valid, resp0_valid, resp1_valid, dmi_resp_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 00000", {busy, dmi_req_valid, resp0_valid, resp1_valid, dmi_resp_ready}); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready_idle: got %b expected 00", {req0_ready, req1_ready}); end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_first_tie: got %b expected 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0; #1;
        trst_ni = 1'b1;
    endtask

    task automatic test_round_robin;
        req0 = '{addr: 7'h10, op: dm::DTM_READ, data: 32'h0};
        req1 = '{addr: 7'h11, op: dm::DTM_WRITE, data: 32'hDEADBEEF};
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        checks++; if ({req0_ready, req1_ready, busy} !== 3'b100) begin
            errors++; $display("FAIL rr_tie_grant: got %b expected 100", {req0_ready, req1_ready, busy}); end
        @(negedge tck);
        checks++; if ({dmi_req_valid, busy, req0_ready, req1_ready} !== 4'b1100) begin
            errors++; $display("FAIL rr_req_phase: got %b expected 1100", {dmi_req_valid, busy, req0_ready, req1_ready}); end
        checks++; if ({dmi_req.addr, dmi_req.op} !== {7'h10, 2'd1}) begin
            errors++; $display("FAIL rr_dmi_addr: got %h/%0d expected 10/1", dmi_req.addr, dmi_req.op); end
        req0_valid = 1'b0; dmi_req_ready = 1'b1;
        @(negedge tck);
        checks++; if ({dmi_req_valid, dmi_resp_ready} !== 2'b01) begin
            errors++; $display("FAIL rr_wait_phase: got %b expected 01", {dmi_req_valid, dmi_resp_ready}); end
        dmi_req_ready = 1'b0; dmi_resp = '{data: 32'hCAFE0001, resp: 2'd0}; dmi_resp_valid = 1'b1;
        @(negedge tck);
        dmi_resp_valid = 1'b0;
        checks++; if ({resp0_valid, resp1_valid, dmi_resp_ready} !== 3'b100) begin
            errors++; $display("FAIL rr_resp_valids: got %b expected 100", {resp0_valid, resp1_valid, dmi_resp_ready}); end
        checks++; if ({resp0.data, resp0.resp} !== {32'hCAFE0001, 2'd0}) begin
            errors++; $display("FAIL rr_resp_data: got %h/%0d expected cafe0001/0", resp0.data, resp0.resp); end
        resp0_ready = 1'b1;
        @(negedge tck);
        resp0_ready = 1'b0;
        checks++; if ({resp0_valid, busy, req0_ready, req1_ready} !== 4'b0001) begin
            errors++; $display("FAIL rr_second_grant: got %b expected 0001", {resp0_valid, busy, req0_ready, req1_ready}); end
    endtask

    task automatic test_write_stall;
        @(negedge tck);
        req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (!(dmi_req_valid === 1'b1 && dmi_req === '{addr: 7'h11, op: 2'd2, data: 32'hDEADBEEF})) begin
                errors++; $display("FAIL stall_req_stable[%0d]: got v=%b %h/%0d/%h expected v=1 11/2/deadbeef", i, dmi_req_valid, dmi_req.addr, dmi_req.op, dmi_req.data); end
            if (i == 5) dmi_req_ready = 1'b1;
            @(negedge tck);
        end
        dmi_req_ready = 1'b0; dmi_resp = '{data: 32'h0, resp: 2'd0}; dmi_resp_valid = 1'b1;
        @(negedge tck);
        dmi_resp_valid = 1'b0;
        checks++; if ({resp1_valid, resp0_valid, resp1.data, resp1.resp} !== {1'b1, 1'b0, 32'h0, 2'd0}) begin
            errors++; $display("FAIL stall_resp1: got v1=%b v0=%b %h/%0d expected v1=1 v0=0 0/0", resp1_valid, resp0_valid, resp1.data, resp1.resp); end
        resp1_ready = 1'b1;
        @(negedge tck);
        resp1_ready = 1'b0;
        checks++; if ({busy, resp1_valid} !== 2'b00) begin
            errors++; $display("FAIL stall_back_idle: got %b expected 00", {busy, resp1_valid}); end
    endtask

    task automatic test_timeout;
        req0 = '{addr: 7'h20, op: dm::DTM_READ, data: 32'h0}; req0_valid = 1'b1;
        @(negedge tck);
        req0_valid = 1'b0; dmi_req_ready = 1'b1;
        @(negedge tck);
        dmi_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({resp0_valid, dmi_resp_ready, busy} !== 3'b011) begin
                errors++; $display("FAIL to_waiting[%0d]: got %b expected 011", i, {resp0_valid, dmi_resp_ready, busy}); end
            @(negedge tck);
        end
        checks++; if ({resp0_valid, resp0.data, resp0.resp} !== {1'b1, 32'h0, 2'd2}) begin
            errors++; $display("FAIL to_synthetic_resp: got v=%b %h/%0d expected v=1 0/2", resp0_valid, resp0.data, resp0.resp); end
        resp0_ready = 1'b1;
        @(negedge tck);
        resp0_ready = 1'b0;
        checks++; if ({busy, dmi_resp_ready} !== 2'b01) begin
            errors++; $display("FAIL to_drop_pending: got %b expected 01", {busy, dmi_resp_ready}); end
    endtask

    task automatic test_late_in_wait;
        req0 = '{addr: 7'h21, op: dm::DTM_NOP, data: 32'h55}; req0_valid = 1'b1;
        @(negedge tck);
        checks++; if ({dmi_req.op, dmi_req.data} !== {2'd0, 32'h55}) begin
            errors++; $display("FAIL late_nop_forward: got %0d/%h expected 0/55", dmi_req.op, dmi_req.data); end
        req0_valid = 1'b0; dmi_req_ready = 1'b1;
        @(negedge tck);
        dmi_req_ready = 1'b0; dmi_resp = '{data: 32'hBAD, resp: 2'd0}; dmi_resp_valid = 1'b1;
        @(negedge tck);
        dmi_resp_valid = 1'b0;
        checks++; if ({resp0_valid, dmi_resp_ready} !== 2'b01) begin
            errors++; $display("FAIL late_discarded: got %b expected 01", {resp0_valid, dmi_resp_ready}); end
        repeat (2) @(negedge tck);
        checks++; if (resp0_valid !== 1'b0) begin
            errors++; $display("FAIL late_early_timeout: got %b expected 0", resp0_valid); end
        @(negedge tck);
        checks++; if ({resp0_valid, resp0.data, resp0.resp} !== {1'b1, 32'h0, 2'd2}) begin
            errors++; $display("FAIL late_counter_ran: got v=%b %h/%0d expected v=1 0/2", resp0_valid, resp0.data, resp0.resp); end
        resp0_ready = 1'b1;
        @(negedge tck);
        resp0_ready = 1'b0; dmi_resp = '{data: 32'h777, resp: 2'd0}; dmi_resp_valid = 1'b1;
        @(negedge tck);
        dmi_resp_valid = 1'b0;
        checks++; if ({dmi_resp_ready, resp0_valid, resp1_valid, busy} !== 4'b0000) begin
            errors++; $display("FAIL late_idle_drop: got %b expected 0000", {dmi_resp_ready, resp0_valid, resp1_valid, busy}); end
    endtask

    task automatic test_coincide;
        req0 = '{addr: 7'h30, op: dm::DTM_READ, data: 32'h0}; req0_valid = 1'b1;
        @(negedge tck);
        req0_valid = 1'b0; dmi_req_ready = 1'b1;
        @(negedge tck);
        dmi_req_ready = 1'b0;
        repeat (3) @(negedge tck);
        dmi_resp = '{data: 32'h1234, resp: 2'd0}; dmi_resp_valid = 1'b1;
        @(negedge tck);
        dmi_resp_valid = 1'b0;
        checks++; if ({resp0_valid, resp0.data, resp0.resp} !== {1'b1, 32'h1234, 2'd0}) begin
            errors++; $display("FAIL coincide_real_wins: got v=%b %h/%0d expected v=1 1234/0", resp0_valid, resp0.data, resp0.resp); end
        checks++; if (dmi_resp_ready !== 1'b0) begin
            errors++; $display("FAIL coincide_no_drop: got %b expected 0", dmi_resp_ready); end
    endtask

    task automatic test_resp_stall;
        req1 = '{addr: 7'h31, op: dm::DTM_READ, data: 32'h0}; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if ({resp0_valid, req1_ready, busy} !== 3'b101) begin
                errors++; $display("FAIL rstall_hold[%0d]: got %b expected 101", i, {resp0_valid, req1_ready, busy}); end
            @(negedge tck);
        end
        resp0_ready = 1'b1;
        @(negedge tck);
        resp0_ready = 1'b0;
        checks++; if ({req0_ready, req1_ready, dmi_resp_ready, busy} !== 4'b0100) begin
            errors++; $display("FAIL rstall_release: got %b expected 0100", {req0_ready, req1_ready, dmi_resp_ready, busy}); end
    endtask

    task automatic test_reset_mid;
        @(negedge tck);
        req1_valid = 1'b0; dmi_req_ready = 1'b1;
        @(negedge tck);
        dmi_req_ready = 1'b0;
        checks++; if ({busy, dmi_resp_ready} !== 2'b11) begin
            errors++; $display("FAIL rmid_in_wait: got %b expected 11", {busy, dmi_resp_ready}); end
        trst_ni = 1'b0;
        @(negedge tck);
        checks++; if ({busy, dmi_req_valid, resp0_valid, resp1_valid, dmi_resp_ready} !== 5'b0) begin
            errors++; $display("FAIL rmid_cleared: got %b expected 00000", {busy, dmi_req_valid, resp0_valid, resp1_valid, dmi_resp_ready}); end
        trst_ni = 1'b1; dmi_resp = '{data: 32'hABCD, resp: 2'd0}; dmi_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge tck);
            checks++; if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin
                errors++; $display("FAIL rmid_no_resp[%0d]: got %b expected 000", i, {resp0_valid, resp1_valid, busy}); end
        end
        dmi_resp_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_write_stall;
        test_timeout;
        test_late_in_wait;
        test_coincide;
        test_resp_stall;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
